// File: rtl/dma_controller_xfer_engine.sv
// DMA transfer engine: accepts a granted channel from the arbiter and moves one
// data beat for it (Avalon-MM read from src, then write to dst), keeping the
// per-channel working address/count registers and pulsing ack/tc/err back.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a grant; latches channel and its src/dst/cnt
// RD_REQ   | read strobe on the bus at src, held through waitrequest
// RD_WAIT  | waiting for readdatavalid, captures the read data
// WR_REQ   | write strobe on the bus at dst, held through waitrequest
// DONE     | ack (and tc/err) visible for one cycle, then back to IDLE
module dma_controller_xfer_engine #(
    parameter int CHANNELS_AMOUNT = 4,
    parameter int CHANNEL_CNT_W   = $clog2(CHANNELS_AMOUNT),
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int CNT_W           = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    input  logic [CHANNEL_CNT_W-1:0]          req_num_i,
    output logic                              ready_o,
    input  logic [CHANNELS_AMOUNT-1:0]        cfg_load_i,
    input  logic [CHANNELS_AMOUNT*ADDR_W-1:0] cfg_src_addr_i,
    input  logic [CHANNELS_AMOUNT*ADDR_W-1:0] cfg_dst_addr_i,
    input  logic [CHANNELS_AMOUNT*CNT_W-1:0]  cfg_cnt_i,
    input  logic [CHANNELS_AMOUNT-1:0]        cfg_src_inc_i,
    input  logic [CHANNELS_AMOUNT-1:0]        cfg_dst_inc_i,
    output logic [CHANNELS_AMOUNT-1:0]        ack_o,
    output logic [CHANNELS_AMOUNT-1:0]        tc_o,
    output logic [CHANNELS_AMOUNT-1:0]        err_o,
    output logic [ADDR_W-1:0]                 m_address_o,
    output logic                              m_read_o,
    output logic                              m_write_o,
    output logic [DATA_W-1:0]                 m_writedata_o,
    input  logic [DATA_W-1:0]                 m_readdata_i,
    input  logic                              m_readdatavalid_i,
    input  logic                              m_waitrequest_i
);

    localparam logic [ADDR_W-1:0]        BEAT_BYTES = ADDR_W'(DATA_W / 8);
    localparam logic [CHANNEL_CNT_W:0]   CH_LIMIT   = (CHANNEL_CNT_W + 1)'(CHANNELS_AMOUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_DONE
    } state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        src_r [CHANNELS_AMOUNT];
    logic [ADDR_W-1:0]        dst_r [CHANNELS_AMOUNT];
    logic [CNT_W-1:0]         cnt_r [CHANNELS_AMOUNT];
    logic [CHANNEL_CNT_W-1:0] ch;
    logic                     ch_ok;
    logic [ADDR_W-1:0]        cur_src;
    logic [ADDR_W-1:0]        cur_dst;
    logic [CNT_W-1:0]         cur_cnt;
    logic                     reload;
    logic                     req_ok;
    logic                     load_active;

    // Out-of-range grants become a silent error beat on a dummy index.
    assign req_ok      = ({1'b0, req_num_i} < CH_LIMIT);
    assign load_active = ch_ok && cfg_load_i[ch];

    // Beat sequencer, per-channel working registers and registered bus/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            ready_o       <= 1'b0;
            ack_o         <= '0;
            tc_o          <= '0;
            err_o         <= '0;
            m_address_o   <= '0;
            m_read_o      <= 1'b0;
            m_write_o     <= 1'b0;
            m_writedata_o <= '0;
            ch            <= '0;
            ch_ok         <= 1'b0;
            cur_src       <= '0;
            cur_dst       <= '0;
            cur_cnt       <= '0;
            reload        <= 1'b0;
            for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
                src_r[i] <= '0;
                dst_r[i] <= '0;
                cnt_r[i] <= '0;
            end
        end else begin
            ack_o <= '0;
            tc_o  <= '0;
            err_o <= '0;

            case (state)
                S_IDLE: begin
                    ready_o <= 1'b1;
                    if (req_valid_i && ready_o) begin
                        ready_o <= 1'b0;
                        ch      <= req_num_i;
                        ch_ok   <= req_ok;
                        reload  <= 1'b0;
                        if (req_ok) begin
                            cur_src <= src_r[req_num_i];
                            cur_dst <= dst_r[req_num_i];
                            cur_cnt <= cnt_r[req_num_i];
                        end
                        if (!req_ok || cnt_r[req_num_i] == '0) begin
                            state <= S_DONE;
                            if (req_ok) begin
                                ack_o[req_num_i] <= 1'b1;
                                err_o[req_num_i] <= 1'b1;
                            end
                        end else begin
                            state       <= S_RD_REQ;
                            m_read_o    <= 1'b1;
                            m_address_o <= src_r[req_num_i];
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!m_waitrequest_i) begin
                        m_read_o <= 1'b0;
                        state    <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (m_readdatavalid_i) begin
                        m_writedata_o <= m_readdata_i;
                        m_address_o   <= cur_dst;
                        m_write_o     <= 1'b1;
                        state         <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!m_waitrequest_i) begin
                        m_write_o <= 1'b0;
                        state     <= S_DONE;
                        if (ch_ok) begin
                            ack_o[ch] <= 1'b1;
                            // A fresh load during the beat owns the registers; skip write-back.
                            if (!(reload || cfg_load_i[ch])) begin
                                src_r[ch] <= cfg_src_inc_i[ch] ? cur_src + BEAT_BYTES : cur_src;
                                dst_r[ch] <= cfg_dst_inc_i[ch] ? cur_dst + BEAT_BYTES : cur_dst;
                                cnt_r[ch] <= cur_cnt - CNT_W'(1);
                                if (cur_cnt == CNT_W'(1))
                                    tc_o[ch] <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    m_read_o  <= 1'b0;
                    m_write_o <= 1'b0;
                end
            endcase

            if (state != S_IDLE && load_active)
                reload <= 1'b1;

            // Loads come last so they win over a coincident write-back.
            for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
                if (cfg_load_i[i]) begin
                    src_r[i] <= cfg_src_addr_i[i*ADDR_W +: ADDR_W];
                    dst_r[i] <= cfg_dst_addr_i[i*ADDR_W +: ADDR_W];
                    cnt_r[i] <= cfg_cnt_i[i*CNT_W +: CNT_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_controller_xfer_engine.sv
// Directed bench for the DMA transfer engine: drives grants, config loads and
// an Avalon-MM slave by hand, checking every output cycle by cycle.
module tb_dma_controller_xfer_engine;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic [1:0]        req_num_i;
    logic              ready_o;
    logic [NCH-1:0]    cfg_load_i;
    logic [NCH*AW-1:0] cfg_src_addr_i;
    logic [NCH*AW-1:0] cfg_dst_addr_i;
    logic [NCH*CW-1:0] cfg_cnt_i;
    logic [NCH-1:0]    cfg_src_inc_i;
    logic [NCH-1:0]    cfg_dst_inc_i;
    logic [NCH-1:0]    ack_o;
    logic [NCH-1:0]    tc_o;
    logic [NCH-1:0]    err_o;
    logic [AW-1:0]     m_address_o;
    logic              m_read_o;
    logic              m_write_o;
    logic [DW-1:0]     m_writedata_o;
    logic [DW-1:0]     m_readdata_i;
    logic              m_readdatavalid_i;
    logic              m_waitrequest_i;

    int n_checks = 0;
    int n_err    = 0;

    dma_controller_xfer_engine dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_num_i         (req_num_i),
        .ready_o           (ready_o),
        .cfg_load_i        (cfg_load_i),
        .cfg_src_addr_i    (cfg_src_addr_i),
        .cfg_dst_addr_i    (cfg_dst_addr_i),
        .cfg_cnt_i         (cfg_cnt_i),
        .cfg_src_inc_i     (cfg_src_inc_i),
        .cfg_dst_inc_i     (cfg_dst_inc_i),
        .ack_o             (ack_o),
        .tc_o              (tc_o),
        .err_o             (err_o),
        .m_address_o       (m_address_o),
        .m_read_o          (m_read_o),
        .m_write_o         (m_write_o),
        .m_writedata_o     (m_writedata_o),
        .m_readdata_i      (m_readdata_i),
        .m_readdatavalid_i (m_readdatavalid_i),
        .m_waitrequest_i   (m_waitrequest_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put_cfg(input int c, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic si, input logic di);
        cfg_src_addr_i[c*AW +: AW] = s;
        cfg_dst_addr_i[c*AW +: AW] = d;
        cfg_cnt_i[c*CW +: CW]      = n;
        cfg_src_inc_i[c]           = si;
        cfg_dst_inc_i[c]           = di;
    endtask

    task automatic load_cfg(input int c, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, input logic si, input logic di);
        put_cfg(c, s, d, n, si, di);
        cfg_load_i[c] = 1'b1;
        tick;
        cfg_load_i = '0;
    endtask

    // One full beat; nwait stall cycles on both read and write phases.
    task automatic beat(input int c, input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] data, input int nwait, input bit tc_exp,
                        input bit load_mid);
        logic [3:0] m;
        m = 4'b0001 << c;
        chk("ready_before_grant", 32'(ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_num_i   = 2'(c);
        tick;
        req_valid_i = 1'b0;
        chk("ready_busy", 32'(ready_o), 32'd0);
        for (int k = 0; k <= nwait; k++) begin
            chk("rd_strobe", 32'(m_read_o), 32'd1);
            chk("rd_addr", m_address_o, s);
            chk("rd_no_write", 32'(m_write_o), 32'd0);
            m_waitrequest_i = (k < nwait);
            tick;
        end
        m_waitrequest_i = 1'b0;
        chk("rd_dropped", 32'(m_read_o), 32'd0);
        m_readdatavalid_i = 1'b1;
        m_readdata_i      = data;
        if (load_mid) cfg_load_i[c] = 1'b1;
        tick;
        m_readdatavalid_i = 1'b0;
        m_readdata_i      = '0;
        cfg_load_i        = '0;
        for (int k = 0; k <= nwait; k++) begin
            chk("wr_strobe", 32'(m_write_o), 32'd1);
            chk("wr_addr", m_address_o, d);
            chk("wr_data", m_writedata_o, data);
            chk("wr_no_read", 32'(m_read_o), 32'd0);
            m_waitrequest_i = (k < nwait);
            if (k < nwait) begin
                m_readdatavalid_i = 1'b1;
                m_readdata_i      = 32'hBAD0_BAD0;
            end
            tick;
            m_readdatavalid_i = 1'b0;
            m_readdata_i      = '0;
        end
        m_waitrequest_i = 1'b0;
        chk("ack_pulse", 32'(ack_o), 32'(m));
        chk("tc_pulse", 32'(tc_o), tc_exp ? 32'(m) : 32'd0);
        chk("err_quiet", 32'(err_o), 32'd0);
        chk("done_no_strobe", 32'({m_read_o, m_write_o}), 32'd0);
        tick;
        chk("ack_cleared", 32'(ack_o), 32'd0);
        chk("tc_cleared", 32'(tc_o), 32'd0);
        chk("ready_again", 32'(ready_o), 32'd1);
    endtask

    task automatic err_grant(input int c);
        logic [3:0] m;
        m = 4'b0001 << c;
        chk("ready_before_err", 32'(ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_num_i   = 2'(c);
        tick;
        req_valid_i = 1'b0;
        chk("err_ack", 32'(ack_o), 32'(m));
        chk("err_err", 32'(err_o), 32'(m));
        chk("err_tc", 32'(tc_o), 32'd0);
        chk("err_no_bus", 32'({m_read_o, m_write_o}), 32'd0);
        tick;
        chk("err_ack_cleared", 32'(ack_o | err_o), 32'd0);
        chk("err_no_bus2", 32'({m_read_o, m_write_o}), 32'd0);
        chk("err_ready_again", 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst_i             = 1'b1;
        req_valid_i       = 1'b0;
        req_num_i         = '0;
        cfg_load_i        = '0;
        cfg_src_addr_i    = '0;
        cfg_dst_addr_i    = '0;
        cfg_cnt_i         = '0;
        cfg_src_inc_i     = '0;
        cfg_dst_inc_i     = '0;
        m_readdata_i      = '0;
        m_readdatavalid_i = 1'b0;
        m_waitrequest_i   = 1'b0;

        // Reset state
        tick;
        tick;
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_strobes", 32'({m_read_o, m_write_o}), 32'd0);
        chk("rst_status", 32'({ack_o, tc_o, err_o}), 32'd0);
        chk("rst_addr", m_address_o, 32'd0);
        chk("rst_wdata", m_writedata_o, 32'd0);
        rst_i = 1'b0;
        tick;
        chk("ready_after_rst", 32'(ready_o), 32'd1);

        // Ch1: both addresses increment, two beats, tc on the second
        load_cfg(1, 32'h0000_0100, 32'h0000_0200, 16'd2, 1'b1, 1'b1);
        beat(1, 32'h0000_0100, 32'h0000_0200, 32'h1111_1111, 0, 1'b0, 1'b0);
        beat(1, 32'h0000_0104, 32'h0000_0204, 32'h2222_2222, 0, 1'b1, 1'b0);

        // Ch0: fixed source, incrementing destination; middle beat stalls 3 cycles each phase
        load_cfg(0, 32'h0000_1000, 32'h0000_2000, 16'd3, 1'b0, 1'b1);
        beat(0, 32'h0000_1000, 32'h0000_2000, 32'hA5A5_0001, 0, 1'b0, 1'b0);
        beat(0, 32'h0000_1000, 32'h0000_2004, 32'hA5A5_0002, 3, 1'b0, 1'b0);
        beat(0, 32'h0000_1000, 32'h0000_2008, 32'hA5A5_0003, 0, 1'b1, 1'b0);
        err_grant(0);

        // Ch2 never loaded: count 0 gives an error beat
        err_grant(2);

        // Ch1 reloaded while its beat is in flight: no write-back, no tc
        load_cfg(1, 32'h0000_0110, 32'h0000_0210, 16'd1, 1'b1, 1'b1);
        put_cfg(1, 32'h0000_0300, 32'h0000_0400, 16'd5, 1'b1, 1'b1);
        beat(1, 32'h0000_0110, 32'h0000_0210, 32'h3333_3333, 0, 1'b0, 1'b1);
        beat(1, 32'h0000_0300, 32'h0000_0400, 32'h4444_4444, 0, 1'b0, 1'b0);

        // Ch3: source wraps past the top of the address space
        load_cfg(3, 32'hFFFF_FFFC, 32'h0000_0500, 16'd2, 1'b1, 1'b1);
        beat(3, 32'hFFFF_FFFC, 32'h0000_0500, 32'h5555_5555, 0, 1'b0, 1'b0);

        // Second ch3 beat, then reset during the write phase
        req_valid_i = 1'b1;
        req_num_i   = 2'd3;
        tick;
        req_valid_i = 1'b0;
        chk("wrap_rd_strobe", 32'(m_read_o), 32'd1);
        chk("wrap_rd_addr", m_address_o, 32'h0000_0000);
        tick;
        m_readdatavalid_i = 1'b1;
        m_readdata_i      = 32'h6666_6666;
        tick;
        m_readdatavalid_i = 1'b0;
        m_readdata_i      = '0;
        chk("wrap_wr_strobe", 32'(m_write_o), 32'd1);
        chk("wrap_wr_addr", m_address_o, 32'h0000_0504);
        rst_i = 1'b1;
        tick;
        chk("rst_mid_write", 32'(m_write_o), 32'd0);
        chk("rst_mid_read", 32'(m_read_o), 32'd0);
        chk("rst_mid_no_ack", 32'(ack_o), 32'd0);
        chk("rst_mid_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b0;
        tick;
        chk("rst_mid_ready_after", 32'(ready_o), 32'd1);
        chk("rst_mid_no_ack_after", 32'(ack_o), 32'd0);

        // Reset cleared every working count
        err_grant(3);
        err_grant(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
